// File: rtl/scarv_cop_mem_arbiter.sv
// Two-requester arbiter sharing one word-aligned memory port. Each response
// arrives one cycle after acceptance and is routed to the port that issued it.
module scarv_cop_mem_arbiter #(
  parameter int unsigned ARB_MODE     = 0,
  parameter int unsigned STARVE_LIMIT = 8
) (
  input  logic        g_clk,
  input  logic        g_resetn,
  input  logic        r0_cen,
  input  logic        r0_wen,
  input  logic [31:0] r0_addr,
  input  logic [31:0] r0_wdata,
  input  logic [3:0]  r0_ben,
  output logic [31:0] r0_rdata,
  output logic        r0_stall,
  output logic        r0_error,
  input  logic        r1_cen,
  input  logic        r1_wen,
  input  logic [31:0] r1_addr,
  input  logic [31:0] r1_wdata,
  input  logic [3:0]  r1_ben,
  output logic [31:0] r1_rdata,
  output logic        r1_stall,
  output logic        r1_error,
  output logic        m_cen,
  output logic        m_wen,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  output logic [3:0]  m_ben,
  input  logic [31:0] m_rdata,
  input  logic        m_stall,
  input  logic        m_error,
  output logic        arb_busy
);

  typedef struct packed {
    logic        cen;
    logic        wen;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  ben;
  } req_t;

  localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);

  req_t [1:0] req;
  req_t       sel;
  logic       grant;
  logic       accept;
  logic       lock;
  logic       lock_port;
  logic       resp_valid;
  logic       resp_owner;
  logic       last_grant;
  logic [7:0] starve_cnt;
  logic [7:0] starve_nxt;

  assign req[0] = {r0_cen, r0_wen, r0_addr, r0_wdata, r0_ben};
  assign req[1] = {r1_cen, r1_wen, r1_addr, r1_wdata, r1_ben};

  // A stalled grant stays put so the memory sees stable fields until it accepts.
  always_comb begin
    grant = r1_cen & ~r0_cen;
    if (lock)
      grant = lock_port;
    else if (r0_cen && r1_cen)
      grant = (ARB_MODE == 0) ? ~last_grant : (starve_cnt >= LIMIT);
  end

  assign sel     = req[grant];
  assign m_cen   = sel.cen & g_resetn;
  assign m_wen   = sel.wen;
  assign m_addr  = sel.addr;
  assign m_wdata = sel.wdata;
  assign m_ben   = sel.ben;
  assign accept  = m_cen & ~m_stall;

  // Stall is also held during reset so no requester mistakes it for acceptance.
  assign r0_stall = r0_cen & (grant | m_stall | ~g_resetn);
  assign r1_stall = r1_cen & (~grant | m_stall | ~g_resetn);

  always_comb begin
    starve_nxt = '0;
    if (ARB_MODE != 0 && r1_cen && !(accept && grant))
      starve_nxt = (starve_cnt == 8'hFF) ? starve_cnt : starve_cnt + 8'd1;
  end

  always_ff @(posedge g_clk) begin
    if (!g_resetn) begin
      lock       <= 1'b0;
      lock_port  <= 1'b0;
      resp_valid <= 1'b0;
      resp_owner <= 1'b0;
      last_grant <= 1'b1;
      starve_cnt <= '0;
    end else begin
      resp_valid <= accept;
      starve_cnt <= starve_nxt;
      if (accept) begin
        resp_owner <= grant;
        last_grant <= grant;
        lock       <= 1'b0;
      end else if (m_cen) begin
        lock      <= 1'b1;
        lock_port <= grant;
      end
    end
  end

  // Routing keys off the registered owner, so a new acceptance never mixes responses.
  assign r0_rdata = (resp_valid && !resp_owner) ? m_rdata : '0;
  assign r0_error = resp_valid & ~resp_owner & m_error;
  assign r1_rdata = (resp_valid && resp_owner) ? m_rdata : '0;
  assign r1_error = resp_valid & resp_owner & m_error;
  assign arb_busy = lock | resp_valid;

endmodule

// File: tb/tb_scarv_cop_mem_arbiter.sv
// Randomized bench for the memory arbiter: round-robin (inst 0) and fixed
// priority with STARVE_LIMIT=3 (inst 1), checked against a behavioural model.
module tb_scarv_cop_mem_arbiter;

  logic g_clk = 1'b0;
  logic g_resetn = 1'b0;
  always #5 g_clk = ~g_clk;

  logic        cen   [2][2];
  logic        wen   [2][2];
  logic        stall [2][2];
  logic        err   [2][2];
  logic [31:0] addr  [2][2];
  logic [31:0] wdata [2][2];
  logic [31:0] rdata [2][2];
  logic [3:0]  ben   [2][2];
  logic        m_cen [2];
  logic        m_wen [2];
  logic        m_stall [2];
  logic        m_error [2];
  logic        arb_busy [2];
  logic [31:0] m_addr  [2];
  logic [31:0] m_wdata [2];
  logic [31:0] m_rdata [2];
  logic [3:0]  m_ben   [2];

  for (genvar gi = 0; gi < 2; gi++) begin : g_dut
    scarv_cop_mem_arbiter #(.ARB_MODE(gi), .STARVE_LIMIT(gi == 1 ? 3 : 8)) dut (
      .g_clk    (g_clk),
      .g_resetn (g_resetn),
      .r0_cen   (cen[gi][0]),
      .r0_wen   (wen[gi][0]),
      .r0_addr  (addr[gi][0]),
      .r0_wdata (wdata[gi][0]),
      .r0_ben   (ben[gi][0]),
      .r0_rdata (rdata[gi][0]),
      .r0_stall (stall[gi][0]),
      .r0_error (err[gi][0]),
      .r1_cen   (cen[gi][1]),
      .r1_wen   (wen[gi][1]),
      .r1_addr  (addr[gi][1]),
      .r1_wdata (wdata[gi][1]),
      .r1_ben   (ben[gi][1]),
      .r1_rdata (rdata[gi][1]),
      .r1_stall (stall[gi][1]),
      .r1_error (err[gi][1]),
      .m_cen    (m_cen[gi]),
      .m_wen    (m_wen[gi]),
      .m_addr   (m_addr[gi]),
      .m_wdata  (m_wdata[gi]),
      .m_ben    (m_ben[gi]),
      .m_rdata  (m_rdata[gi]),
      .m_stall  (m_stall[gi]),
      .m_error  (m_error[gi]),
      .arb_busy (arb_busy[gi])
    );
  end

  typedef struct {
    int inst;
    bit rst;
    int acc;   // 0 none, 1 port 0, 2 port 1
    bit busy;
  } exp_t;

  typedef struct {
    bit          wr;
    bit          err;
    logic [31:0] rdata;
  } rsp_t;

  exp_t expq [$];
  rsp_t respq [4][$];

  int errors = 0;
  int checks = 0;

  logic [31:0] mem  [2][64];
  logic [31:0] refm [2][64];

  // requester / memory-side state as seen by the stimulus
  bit          pend [2][2];
  bit          oacc [2][2];
  bit          macc [2];
  bit          ms_wen [2];
  logic [31:0] ms_addr [2];
  logic [31:0] ms_wdata [2];
  logic [3:0]  ms_ben [2];

  // reference model: who was served last, how long port 1 has waited,
  // which port owns a stalled transfer, whether a response is due
  int mlast [2];
  int mwait [2];
  int mlockp [2];
  bit mlock [2];
  bit mresp [2];

  int prev_obs [2];

  function automatic int mem_idx(logic [31:0] a);
    return int'({a[13:12], a[5:2]});
  endfunction

  function automatic logic [31:0] merge(logic [31:0] old, logic [31:0] nw, logic [3:0] be);
    logic [31:0] r = old;
    for (int b = 0; b < 4; b++)
      if (be[b]) r[8*b +: 8] = nw[8*b +: 8];
    return r;
  endfunction

  task automatic chk(string nm, int i, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s inst%0d: got %0h expected %0h at %0t", nm, i, act, exp, $time);
    end
  endtask

  task automatic issue(int i, int p, int wr_pct);
    rsp_t r;
    bit   e;
    int   k;
    e = ($urandom_range(0, 3) == 0);
    addr[i][p]  = (32'(p) << 13) | (32'(e) << 12) | (32'($urandom_range(0, 15)) << 2);
    wen[i][p]   = ($urandom_range(0, 99) < wr_pct);
    wdata[i][p] = $urandom;
    ben[i][p]   = 4'($urandom_range(1, 15));
    k = mem_idx(addr[i][p]);
    r.err = e;
    r.wr  = wen[i][p];
    r.rdata = '0;
    if (wen[i][p]) refm[i][k] = merge(refm[i][k], wdata[i][p], ben[i][p]);
    else r.rdata = refm[i][k];
    respq[i*2+p].push_back(r);
    pend[i][p] = 1'b1;
  endtask

  task automatic model_step(int i, bit rst);
    exp_t e;
    int   w;
    int   a;
    bit   c0;
    bit   c1;
    e.inst = i;
    e.rst  = rst;
    e.busy = mlock[i] | mresp[i];
    e.acc  = 0;
    if (rst) begin
      mlast[i] = 1; mwait[i] = 0; mlock[i] = 1'b0; mresp[i] = 1'b0;
    end else begin
      c0 = cen[i][0];
      c1 = cen[i][1];
      w = -1;
      if (mlock[i]) w = mlockp[i];
      else if (c0 && c1) w = (i == 0) ? 1 - mlast[i] : ((mwait[i] >= 3) ? 1 : 0);
      else if (c0) w = 0;
      else if (c1) w = 1;
      a = (w >= 0 && !m_stall[i]) ? w : -1;
      if (w >= 0 && m_stall[i]) begin mlock[i] = 1'b1; mlockp[i] = w; end
      if (a >= 0) begin mlock[i] = 1'b0; mlast[i] = a; end
      mresp[i] = (a >= 0);
      if (i == 1) mwait[i] = (c1 && a != 1) ? ((mwait[i] < 255) ? mwait[i] + 1 : 255) : 0;
      e.acc = a + 1;
    end
    expq.push_back(e);
  endtask

  task automatic drive_cycle(int req_pct, int stl_pct, int wr_pct, bit rst);
    g_resetn = !rst;
    for (int i = 0; i < 2; i++) begin
      if (macc[i]) begin
        int k = mem_idx(ms_addr[i]);
        m_error[i] = ms_addr[i][12];
        if (ms_wen[i]) begin
          mem[i][k]  = merge(mem[i][k], ms_wdata[i], ms_ben[i]);
          m_rdata[i] = $urandom;
        end else m_rdata[i] = mem[i][k];
      end else begin
        m_rdata[i] = $urandom;
        m_error[i] = 1'($urandom_range(0, 1));
      end
      m_stall[i] = ($urandom_range(0, 99) < stl_pct);
      for (int p = 0; p < 2; p++) begin
        if (oacc[i][p]) pend[i][p] = 1'b0;
        if (rst) begin
          pend[i][p]  = 1'b0;
          cen[i][p]   = 1'b1;
          wen[i][p]   = 1'($urandom_range(0, 1));
          addr[i][p]  = $urandom;
          respq[i*2+p].delete();
        end else begin
          if (!pend[i][p] && $urandom_range(0, 99) < req_pct) issue(i, p, wr_pct);
          cen[i][p] = pend[i][p];
        end
      end
      model_step(i, rst);
    end
  endtask

  task automatic sample_cycle();
    for (int i = 0; i < 2; i++) begin
      macc[i]     = m_cen[i] & ~m_stall[i];
      ms_wen[i]   = m_wen[i];
      ms_addr[i]  = m_addr[i];
      ms_wdata[i] = m_wdata[i];
      ms_ben[i]   = m_ben[i];
      for (int p = 0; p < 2; p++) oacc[i][p] = cen[i][p] & ~stall[i][p];
    end
  endtask

  task automatic run_phase(int n, int req_pct, int stl_pct, int wr_pct, bit rst);
    repeat (n) begin
      @(posedge g_clk);
      #1;
      drive_cycle(req_pct, stl_pct, wr_pct, rst);
      @(negedge g_clk);
      sample_cycle();
    end
  endtask

  task automatic check_inst(exp_t e);
    int   i = e.inst;
    int   obs = 0;
    rsp_t r;
    if (e.rst) begin
      chk("m_cen_in_reset", i, 64'(m_cen[i]), 64'(0));
      prev_obs[i] = 0;
      return;
    end
    for (int p = 0; p < 2; p++)
      if (cen[i][p] && !stall[i][p]) obs += p + 1;
    chk("accepted_port", i, 64'(obs), 64'(e.acc));
    chk("arb_busy", i, 64'(arb_busy[i]), 64'(e.busy));
    if (obs == 1 || obs == 2) begin
      int p = obs - 1;
      chk("m_cen", i, 64'(m_cen[i] & ~m_stall[i]), 64'(1));
      chk("m_addr", i, 64'(m_addr[i]), 64'(addr[i][p]));
      chk("m_wen", i, 64'(m_wen[i]), 64'(wen[i][p]));
      chk("m_wdata", i, 64'(m_wdata[i]), 64'(wdata[i][p]));
      chk("m_ben", i, 64'(m_ben[i]), 64'(ben[i][p]));
    end
    for (int p = 0; p < 2; p++) begin
      if (prev_obs[i] == p + 1) begin
        if (respq[i*2+p].size() == 0) begin
          checks++;
          errors++;
          $display("FAIL resp_queue inst%0d port%0d: response with no outstanding request", i, p);
        end else begin
          r = respq[i*2+p].pop_front();
          chk($sformatf("r%0d_error", p), i, 64'(err[i][p]), 64'(r.err));
          if (!r.wr) chk($sformatf("r%0d_rdata", p), i, 64'(rdata[i][p]), 64'(r.rdata));
        end
      end else begin
        chk($sformatf("r%0d_idle_resp", p), i, 64'({err[i][p], rdata[i][p]}), 64'(0));
      end
    end
    prev_obs[i] = obs;
  endtask

  always @(negedge g_clk) begin
    exp_t e;
    while (expq.size() > 0) begin
      e = expq.pop_front();
      check_inst(e);
    end
  end

  initial begin
    for (int i = 0; i < 2; i++) begin
      for (int k = 0; k < 64; k++) begin
        mem[i][k]  = 32'hDEADBEEF ^ (32'(i * 64 + k) * 32'h01010101);
        refm[i][k] = mem[i][k];
      end
      for (int p = 0; p < 2; p++) begin
        cen[i][p] = 1'b0; wen[i][p] = 1'b0; addr[i][p] = '0;
        wdata[i][p] = '0; ben[i][p] = '0; pend[i][p] = 1'b0; oacc[i][p] = 1'b0;
      end
      m_stall[i] = 1'b0; m_error[i] = 1'b0; m_rdata[i] = '0; macc[i] = 1'b0;
      ms_wen[i] = 1'b0; ms_addr[i] = '0; ms_wdata[i] = '0; ms_ben[i] = '0;
      mlast[i] = 1; mwait[i] = 0; mlockp[i] = 0; mlock[i] = 1'b0; mresp[i] = 1'b0;
      prev_obs[i] = 0;
    end
    run_phase(3,   0,   0,  0,  1'b1);
    run_phase(30,  100, 0,  50, 1'b0);
    run_phase(200, 60,  30, 50, 1'b0);
    run_phase(150, 90,  60, 50, 1'b0);
    run_phase(8,   100, 0,  0,  1'b0);
    run_phase(2,   100, 0,  0,  1'b1);
    run_phase(30,  100, 0,  50, 1'b0);
    run_phase(150, 50,  25, 50, 1'b0);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
